top_brom: RTL and testbench



---
 rtl/top_brom_pkg.sv | 19 +
 rtl/brom_rom.sv | 33 +++
 rtl/top_brom.sv | 80 ++++++++
 tb/tb_top_brom.sv | 124 ++++++++++++
 4 files changed

// File: rtl/top_brom_pkg.sv
// Shared constants, FSM state type and default ROM image for the ROM maximum finder.
package top_brom_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [DEF_DATA_W-1:0] DEF_IMAGE [DEF_DEPTH] = '{
        4'd3, 4'd7, 4'd1, 4'd9, 4'd4, 4'd2, 4'd8, 4'd5,
        4'd0, 4'd6, 4'd11, 4'd10, 4'd2, 4'd13, 4'd12, 4'd1
    };

endpackage

// File: rtl/brom_rom.sv
// Synchronous single-port ROM with a registered read port, written so BRAM is inferred.
module brom_rom
    import top_brom_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    typedef logic [DATA_W-1:0] image_t [DEPTH];

    // Words past the default image read as zero.
    function automatic image_t load_image();
        image_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = (i < DEF_DEPTH) ? DATA_W'(DEF_IMAGE[i % DEF_DEPTH]) : '0;
        end
        return img;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH] = load_image();

    // NOTE: neither the array nor q is reset; a reset on the read register would block BRAM inference.
    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/top_brom.sv
// Walks every ROM word once after reset and holds the largest unsigned value on Max.
module top_brom
    import top_brom_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    DEPTH     = DEF_DEPTH,
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] Max,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic              rd_valid;
    logic [DATA_W-1:0] q;
    logic              last_addr;
    logic              addr_en;
    logic              read_en;
    logic              cmp_en;
    logic              finish;

    brom_rom #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .clk (clk),
        .addr(addr),
        .q   (q)
    );

    assign last_addr = (addr == ADDR_W'(DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_next;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (last_addr) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        addr_en = (state == SCAN) && !last_addr;
        read_en = (state == SCAN);
        cmp_en  = rd_valid && (state != DONE);
        finish  = (state == DRAIN);
    end

    // The DRAIN edge performs the last compare and raises done together, so Max is final when done is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            rd_valid <= 1'b0;
            Max      <= '0;
            done     <= 1'b0;
        end else begin
            if (addr_en) addr <= addr + 1'b1;
            if (read_en)     rd_valid <= 1'b1;
            else if (finish) rd_valid <= 1'b0;
            if (cmp_en && (q > Max)) Max <= q;
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_top_brom.sv
// Self-checking bench: backdoor-loads ROM images and compares Max/done against a prefix-maximum model.
module tb_top_brom;
    import top_brom_pkg::*;

    localparam int DATA_W = DEF_DATA_W;
    localparam int DEPTH  = DEF_DEPTH;
    localparam int ADDR_W = DEF_ADDR_W;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] Max;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] image [DEPTH];

    top_brom #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .INIT_FILE("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .Max (Max),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: after edge n of a scan, Max is the maximum of words 0..n-2; done from edge DEPTH+1 on.
    function automatic logic [DATA_W-1:0] exp_max(input int n);
        logic [DATA_W-1:0] m = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k <= n - 2 && image[k] > m) m = image[k];
        end
        return m;
    endfunction

    task automatic hold_reset(input string tag, input int cycles);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) dut.u_rom.mem[i] = image[i];
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            check({tag, " rst max"}, 32'(Max), 32'd0);
            check({tag, " rst done"}, 32'(done), 32'd0);
        end
        rst = 1'b0;
    endtask

    task automatic run_edges(input string tag, input int first, input int last);
        for (int n = first; n <= last; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s E%0d max", tag, n), 32'(Max), 32'(exp_max(n)));
            check($sformatf("%s E%0d done", tag, n), 32'(done), 32'(n >= DEPTH + 1));
        end
    endtask

    task automatic scan(input string tag);
        hold_reset(tag, 3);
        run_edges(tag, 1, DEPTH + 4);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) image[i] = DEF_IMAGE[i];

        // Default image, long reset, then a long hold after done.
        hold_reset("default", 5);
        run_edges("default", 1, DEPTH + 1 + 20);
        check("default final", 32'(Max), 32'd13);

        // Reset at E8, held for two edges, then a full rescan.
        hold_reset("abort", 5);
        run_edges("abort", 1, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort E8 max", 32'(Max), 32'd0);
        check("abort E8 done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("abort E9 max", 32'(Max), 32'd0);
        rst = 1'b0;
        run_edges("abort rerun", 1, DEPTH + 4);
        check("abort final", 32'(Max), 32'd13);

        for (int i = 0; i < DEPTH; i++) image[i] = DATA_W'(i);
        scan("ascending");

        for (int i = 0; i < DEPTH; i++) image[i] = '0;
        scan("zeros");

        for (int i = 0; i < DEPTH; i++) image[i] = (i == 0) ? DATA_W'(15) : DATA_W'(1);
        scan("max_first");

        for (int i = 0; i < DEPTH; i++) image[i] = DATA_W'(i % 9);
        image[3] = DATA_W'(9);
        image[7] = DATA_W'(9);
        scan("ties");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) image[i] = DATA_W'($urandom_range(0, 2**DATA_W - 1));
            scan($sformatf("random%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
